disp_syncgen: RTL and testbench

//  Pixel-clock stage directly downstream of the VRAM AXI read controller. Generates 640x480 VGA timing.

---
 rtl/disp_syncgen.sv | 130 +++++++++++++
 tb/tb_disp_syncgen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_syncgen.sv
// disp_syncgen: VGA timing generator that drains the pixel FIFO into registered RGB/HS/VS/DE and requests one VRAM fetch per frame.
// Optional macro DISP_COLORBAR_EN: show 8 vertical colour bars instead of black while the display is off.
module disp_syncgen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        DCLK,
    input  logic        DRST_N,
    input  logic        DISPON,
    input  logic        FIFO_EMPTY,
    input  logic [31:0] FIFO_DOUT,
    output logic        FIFO_RD,
    output logic        AXISTART,
    input  logic        UF_CLR,
    output logic        UNDERFLOW,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_DE
);
    localparam int H_PERIOD = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_PERIOD = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_PERIOD);
    localparam int VW = $clog2(V_PERIOD);
    localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_S0  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_S1  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_END = HW'(H_PERIOD - 1);
    localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_S0  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_S1  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_END = VW'(V_PERIOD - 1);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          frame_on_q, frame_on_d;
    logic          axistart_q, axistart_d;
    logic          uf_q, uf_d;
    logic          pop1_q, pop1_d, act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic          active;
    logic          unused_hi;
`ifdef DISP_COLORBAR_EN
    localparam logic [HW-1:0] H_BAR = HW'(H_ACTIVE / 8);
    logic [23:0] bar1_q, bar1_d;
    logic [2:0]  bar_k;
`endif

    assign unused_hi = ^FIFO_DOUT[31:24];

    always_comb begin
        active     = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hcnt_d     = (hcnt_q == H_END) ? '0 : hcnt_q + 1'b1;
        vcnt_d     = (hcnt_q != H_END) ? vcnt_q : (vcnt_q == V_END) ? '0 : vcnt_q + 1'b1;
        // AXISTART and frame_on decode the next count so they change on the edge that enters the VS lines
        axistart_d = (vcnt_d >= V_S0) && (vcnt_d < V_S1);
        frame_on_d = (hcnt_d == '0 && vcnt_d == V_S0) ? DISPON : frame_on_q;
        FIFO_RD    = active && frame_on_q && !FIFO_EMPTY;
        uf_d       = (active && frame_on_q && FIFO_EMPTY) || (uf_q && !UF_CLR);
        pop1_d     = FIFO_RD;
        act1_d     = active;
        hs1_d      = (hcnt_q >= H_S0 && hcnt_q < H_S1) ? SYNC_POL : ~SYNC_POL;
        vs1_d      = (vcnt_q >= V_S0 && vcnt_q < V_S1) ? SYNC_POL : ~SYNC_POL;
        hs_d       = hs1_q;
        vs_d       = vs1_q;
        de_d       = act1_q;
`ifdef DISP_COLORBAR_EN
        bar_k      = 3'd7 - 3'(hcnt_q / H_BAR);
        bar1_d     = frame_on_q ? '0 : {{8{bar_k[2]}}, {8{bar_k[1]}}, {8{bar_k[0]}}};
        rgb_d      = pop1_q ? FIFO_DOUT[23:0] : act1_q ? bar1_q : '0;
`else
        rgb_d      = pop1_q ? FIFO_DOUT[23:0] : '0;
`endif
    end

    always_ff @(posedge DCLK or negedge DRST_N) begin
        if (!DRST_N) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            frame_on_q <= 1'b0;
            axistart_q <= 1'b0;
            uf_q       <= 1'b0;
            pop1_q     <= 1'b0;
            act1_q     <= 1'b0;
            hs1_q      <= ~SYNC_POL;
            vs1_q      <= ~SYNC_POL;
            rgb_q      <= '0;
            hs_q       <= ~SYNC_POL;
            vs_q       <= ~SYNC_POL;
            de_q       <= 1'b0;
`ifdef DISP_COLORBAR_EN
            bar1_q     <= '0;
`endif
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            frame_on_q <= frame_on_d;
            axistart_q <= axistart_d;
            uf_q       <= uf_d;
            pop1_q     <= pop1_d;
            act1_q     <= act1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            rgb_q      <= rgb_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
`ifdef DISP_COLORBAR_EN
            bar1_q     <= bar1_d;
`endif
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign VGA_HS    = hs_q;
    assign VGA_VS    = vs_q;
    assign VGA_DE    = de_q;
    assign AXISTART  = axistart_q;
    assign UNDERFLOW = uf_q;
endmodule

// File: tb/tb_disp_syncgen.sv
// tb_disp_syncgen: self-checking bench for disp_syncgen on a shrunken raster with a reference timing model and output scoreboard.
module tb_disp_syncgen;
    localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
    localparam int VA = 6, VF = 2, VSY = 2, VB = 2;
    localparam int HP = HA + HF + HSY + HB;
    localparam int VP = VA + VF + VSY + VB;
    localparam int FRAME = HP * VP;
`ifdef DISP_COLORBAR_EN
    localparam bit CB = 1'b1;
`else
    localparam bit CB = 1'b0;
`endif

    logic        DCLK = 1'b0;
    logic        DRST_N, DISPON, FIFO_EMPTY, UF_CLR;
    logic [31:0] FIFO_DOUT = 32'h0;
    logic        FIFO_RD, AXISTART, UNDERFLOW;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_DE;

    disp_syncgen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .DCLK(DCLK), .DRST_N(DRST_N), .DISPON(DISPON), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_DOUT(FIFO_DOUT), .FIFO_RD(FIFO_RD), .AXISTART(AXISTART),
        .UF_CLR(UF_CLR), .UNDERFLOW(UNDERFLOW),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE)
    );

    always #5 DCLK = ~DCLK;

    // FIFO model: data is the pop index, upper byte is junk the DUT must ignore
    logic [31:0] fifo_pix = 32'h0;
    always @(posedge DCLK) begin
        if (FIFO_RD) begin
            FIFO_DOUT <= {8'hA5, fifo_pix[23:0]};
            fifo_pix  <= fifo_pix + 1;
        end
    end

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
    } exp_t;

    typedef struct {
        logic empty;
        logic clr;
        logic rd;
        logic uf;
    } vec_t;

    int checks = 0, failures = 0;
    int mh, mv, cyc, n_rd, n_de;
    logic mframe, maxi, muf, axi_prev;
    logic [31:0] mpix = 32'h0;
    exp_t q[$];
    int rises[$], falls[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s got=%0h want=%0h cyc=%0d h=%0d v=%0d", name, got, want, cyc, mh, mv);
        end
    endtask

    function automatic logic [23:0] bar(input int h);
        logic [2:0] k;
        k = 3'(7 - h / (HA / 8));
        return CB ? {{8{k[2]}}, {8{k[1]}}, {8{k[0]}}} : 24'h0;
    endfunction

    task automatic model_reset();
        exp_t e;
        e.rgb = 24'h0; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
        mh = 0; mv = 0; mframe = 1'b0; maxi = 1'b0; muf = 1'b0;
        q.delete();
        q.push_back(e);
        cyc = 0; axi_prev = 1'b0;
    endtask

    // One DCLK: check the combinational pop, push the expected pixel, advance, compare the registered outputs
    task automatic step();
        logic act, pop, nuf, nfr;
        exp_t e, g;
        int nh, nv;
        #1;
        act = (mh < HA) && (mv < VA);
        pop = act && mframe && !FIFO_EMPTY;
        chk("fifo_rd", 32'(FIFO_RD), 32'(pop));
        e.rgb = pop ? mpix[23:0] : (act && !mframe) ? bar(mh) : 24'h0;
        e.hs  = (mh >= HA + HF && mh < HA + HF + HSY) ? 1'b0 : 1'b1;
        e.vs  = (mv >= VA + VF && mv < VA + VF + VSY) ? 1'b0 : 1'b1;
        e.de  = act;
        if (pop) mpix++;
        nh  = (mh == HP - 1) ? 0 : mh + 1;
        nv  = (mh != HP - 1) ? mv : (mv == VP - 1) ? 0 : mv + 1;
        nuf = (act && mframe && FIFO_EMPTY) || (muf && !UF_CLR);
        nfr = (nh == 0 && nv == VA + VF) ? DISPON : mframe;
        q.push_back(e);
        n_rd += int'(FIFO_RD);
        @(posedge DCLK);
        #1;
        mh = nh; mv = nv; muf = nuf; mframe = nfr;
        maxi = (nv >= VA + VF) && (nv < VA + VF + VSY);
        g = q.pop_front();
        chk("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, g.rgb});
        chk("hs", 32'(VGA_HS), 32'(g.hs));
        chk("vs", 32'(VGA_VS), 32'(g.vs));
        chk("de", 32'(VGA_DE), 32'(g.de));
        chk("axistart", 32'(AXISTART), 32'(maxi));
        chk("underflow", 32'(UNDERFLOW), 32'(muf));
        cyc++;
        if (AXISTART && !axi_prev) rises.push_back(cyc);
        if (!AXISTART && axi_prev) falls.push_back(cyc);
        axi_prev = AXISTART;
        n_de += int'(VGA_DE);
    endtask

    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(mh == h && mv == v) && n < 2 * FRAME);
        chk("wait_pos", 32'(mh == h && mv == v), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hs"}, 32'(VGA_HS), 32'd1);
        chk({tag, "_vs"}, 32'(VGA_VS), 32'd1);
        chk({tag, "_de"}, 32'(VGA_DE), 32'd0);
        chk({tag, "_rgb"}, {8'h0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk({tag, "_rd"}, 32'(FIFO_RD), 32'd0);
        chk({tag, "_axi"}, 32'(AXISTART), 32'd0);
        chk({tag, "_uf"}, 32'(UNDERFLOW), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[12];
        int rd0, de0, hl, vl, nde, n;
        logic [7:0] b0, b1;
        logic [23:0] first_rgb, last_rgb;
        logic seen;
        // underflow / UF_CLR sequence on one active line: {empty, clr, expected FIFO_RD, expected UNDERFLOW after edge}
        tv[0]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        tv[7]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tv[10] = '{1'b0, 1'b0, 1'b1, 1'b1};
        tv[11] = '{1'b0, 1'b1, 1'b1, 1'b0};

        DRST_N = 1'b0; DISPON = 1'b0; FIFO_EMPTY = 1'b0; UF_CLR = 1'b0;
        n_rd = 0; n_de = 0; cyc = 0; mh = 0; mv = 0;
        repeat (3) @(posedge DCLK);
        #1;
        chk_reset_outputs("rst");
        DRST_N = 1'b1;
        model_reset();

        // Display off for two frames: timing only, no pops
        rd0 = n_rd; de0 = n_de; hl = 0; vl = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            hl += int'(!VGA_HS);
            vl += int'(!VGA_VS);
        end
        chk("de_count", 32'(n_de - de0), 32'(2 * HA * VA));
        chk("rd_count_off", 32'(n_rd - rd0), 32'd0);
        chk("hs_low_count", 32'(hl), 32'(2 * VP * HSY));
        chk("vs_low_count", 32'(vl), 32'(2 * VSY * HP));
        chk("axi_rises", 32'(rises.size()), 32'd2);
        if (rises.size() >= 2 && falls.size() >= 1) begin
            chk("axi_first_rise", 32'(rises[0]), 32'((VA + VF) * HP));
            chk("axi_high_len", 32'(falls[0] - rises[0]), 32'(VSY * HP));
            chk("axi_period", 32'(rises[1] - rises[0]), 32'(FRAME));
        end

        // Display on: the frame after the next AXISTART rise pops every pixel in order
        DISPON = 1'b1;
        wait_pos(0, 0);
        rd0 = n_rd; nde = 0; b0 = 8'hEE; b1 = 8'hEE;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (VGA_DE) begin
                if (nde == 0) b0 = VGA_B;
                if (nde == 1) b1 = VGA_B;
                nde++;
            end
        end
        chk("pops_per_frame", 32'(n_rd - rd0), 32'(HA * VA));
        chk("first_b", 32'(b0), 32'h00);
        chk("second_b", 32'(b1), 32'h01);
        chk("de_on_frame", 32'(nde), 32'(HA * VA));

        // Underflow sequence mid-frame
        wait_pos(0, 1);
        for (int i = 0; i < 12; i++) begin
            FIFO_EMPTY = tv[i].empty;
            UF_CLR = tv[i].clr;
            #1;
            chk($sformatf("tv%0d_rd", i), 32'(FIFO_RD), 32'(tv[i].rd));
            step();
            chk($sformatf("tv%0d_uf", i), 32'(UNDERFLOW), 32'(tv[i].uf));
        end
        FIFO_EMPTY = 1'b0;
        UF_CLR = 1'b0;

        // DISPON dropped mid-frame: this frame still drains, the next one is idle
        wait_pos(0, 0);
        rd0 = n_rd;
        wait_pos(0, 2);
        DISPON = 1'b0;
        wait_pos(0, 0);
        chk("pops_after_drop", 32'(n_rd - rd0), 32'(HA * VA));
        rd0 = n_rd; seen = 1'b0; first_rgb = 24'h123456; last_rgb = 24'h123456;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (VGA_DE) begin
                if (!seen) first_rgb = {VGA_R, VGA_G, VGA_B};
                last_rgb = {VGA_R, VGA_G, VGA_B};
                seen = 1'b1;
            end
        end
        chk("pops_idle_frame", 32'(n_rd - rd0), 32'd0);
        chk("idle_first_px", {8'h0, first_rgb}, CB ? 32'hFFFFFF : 32'h0);
        chk("idle_last_px", {8'h0, last_rgb}, 32'h0);

        // Asynchronous reset in the middle of a popping frame with UNDERFLOW set
        DISPON = 1'b1;
        wait_pos(0, 0);
        wait_pos(6, 3);
        FIFO_EMPTY = 1'b1;
        step();
        FIFO_EMPTY = 1'b0;
        #2;
        DRST_N = 1'b0;
        #1;
        chk_reset_outputs("arst");
        repeat (3) @(posedge DCLK);
        #1;
        DRST_N = 1'b1;
        model_reset();
        n = 0;
        while (VGA_HS !== 1'b0 && n < 4 * HP) begin
            step();
            n++;
        end
        chk("hs_after_reset", 32'(cyc), 32'(HA + HF + 2));
        for (int i = 0; i < 2 * HP; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
